// File: rtl/valid_join_pkg.sv
// Shared definitions for the valid-only join receiver: default sizing and the modular adder.
package valid_join_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_DEPTH = 4;
  localparam int DEFAULT_CW    = $clog2(DEFAULT_DEPTH + 1);

  typedef logic [DEFAULT_CW-1:0] cnt_t;

  // Sum of two words kept to the low w bits (carry out discarded); w may be 1..64.
  function automatic logic [63:0] mod_add(input logic [63:0] x,
                                          input logic [63:0] y,
                                          input int unsigned w);
    logic [63:0] mask;
    mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    return (x + y) & mask;
  endfunction

endpackage

// File: rtl/valid_fifo.sv
// Input buffer for one valid-only stream: head is visible the cycle after the write, no bypass.
// Cannot stall the writer; a write into a full FIFO with no pop is dropped and flagged by drop.
module valid_fifo
  import valid_join_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH,
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count,
  output logic             drop
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             wr_ok;

  // A pop in the same cycle frees the slot, so a full FIFO can still take the word.
  assign full  = (count == CW'(DEPTH));
  assign wr_ok = wr_en && (!full || rd_en);
  assign drop  = wr_en && full && !rd_en;
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_ok, rd_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/valid_join_rx.sv
// Joins streams a and e (one word each, FIFO order) into a registered c = a + e; 2-cycle latency, 1/cycle.
// out_cReady stalls the join only; input overruns are dropped and latched in sticky ovf_a/ovf_e.
module valid_join_rx
  import valid_join_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_aValid,
  input  logic [WIDTH-1:0] in_a,
  input  logic             in_eValid,
  input  logic [WIDTH-1:0] in_e,
  output logic             out_cValid,
  output logic [WIDTH-1:0] out_c,
  input  logic             out_cReady,
  output logic             ovf_a,
  output logic             ovf_e,
  output logic [CW-1:0]    cnt_a,
  output logic [CW-1:0]    cnt_e,
  input  logic             clr_ovf
);

  logic [WIDTH-1:0] head_a;
  logic [WIDTH-1:0] head_e;
  logic             drop_a;
  logic             drop_e;
  logic             fire;

  assign fire = (cnt_a != '0) && (cnt_e != '0) && (!out_cValid || out_cReady);

  valid_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_a (
    .clk     (clk),
    .rst_n   (reset),
    .wr_en   (in_aValid),
    .wr_data (in_a),
    .rd_en   (fire),
    .head    (head_a),
    .count   (cnt_a),
    .drop    (drop_a)
  );

  valid_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_e (
    .clk     (clk),
    .rst_n   (reset),
    .wr_en   (in_eValid),
    .wr_data (in_e),
    .rd_en   (fire),
    .head    (head_e),
    .count   (cnt_e),
    .drop    (drop_e)
  );

  // Reload on fire even while draining, so back-to-back results carry no bubble.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_cValid <= 1'b0;
      out_c      <= '0;
    end else if (fire) begin
      out_cValid <= 1'b1;
      out_c      <= WIDTH'(mod_add(64'(head_a), 64'(head_e), WIDTH));
    end else if (out_cReady) begin
      out_cValid <= 1'b0;
    end
  end

  // A drop in the same cycle as clr_ovf keeps the flag set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_a <= 1'b0;
      ovf_e <= 1'b0;
    end else begin
      if (drop_a)       ovf_a <= 1'b1;
      else if (clr_ovf) ovf_a <= 1'b0;
      if (drop_e)       ovf_e <= 1'b1;
      else if (clr_ovf) ovf_e <= 1'b0;
    end
  end

endmodule

// File: tb/tb_valid_join_rx.sv
// Bench for valid_join_rx: scoreboard of expected sums checked on every output transfer,
// plus directed checks of counts, flags, latency and reset.
module tb_valid_join_rx;
  import valid_join_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_aValid;
  logic [31:0] in_a;
  logic        in_eValid;
  logic [31:0] in_e;
  logic        out_cValid;
  logic [31:0] out_c;
  logic        out_cReady;
  logic        ovf_a;
  logic        ovf_e;
  logic [2:0]  cnt_a;
  logic [2:0]  cnt_e;
  logic        clr_ovf;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_xfer  = 0;
  int          snap;
  logic [31:0] exp_q[$];

  valid_join_rx #(.WIDTH(32), .DEPTH(4)) dut (
    .clk        (clk),
    .reset      (rst_n),
    .in_aValid  (in_aValid),
    .in_a       (in_a),
    .in_eValid  (in_eValid),
    .in_e       (in_e),
    .out_cValid (out_cValid),
    .out_c      (out_c),
    .out_cReady (out_cReady),
    .ovf_a      (ovf_a),
    .ovf_e      (ovf_e),
    .cnt_a      (cnt_a),
    .cnt_e      (cnt_e),
    .clr_ovf    (clr_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One cycle of stimulus; the words are captured at the next rising edge.
  task automatic cyc_drive(input logic va, input logic [31:0] a, input logic ve, input logic [31:0] e);
    in_aValid = va;
    in_a      = a;
    in_eValid = ve;
    in_e      = e;
    step();
  endtask

  task automatic idle();
    cyc_drive(1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  // Scoreboard: every accepted result must be the oldest outstanding expected sum.
  always @(negedge clk) begin
    if (rst_n && out_cValid && out_cReady) begin
      n_xfer++;
      if (exp_q.size() == 0) chk("extra_result", 32'(exp_q.size()), 32'd1);
      else                   chk("result", out_c, exp_q.pop_front());
    end
  end

  initial begin
    rst_n      = 1'b0;
    in_aValid  = 1'b0;
    in_a       = '0;
    in_eValid  = 1'b0;
    in_e       = '0;
    out_cReady = 1'b1;
    clr_ovf    = 1'b0;
    #12;
    chk("rst_valid", 32'(out_cValid), 32'd0);
    chk("rst_c", out_c, 32'd0);
    chk("rst_ovf", 32'({ovf_a, ovf_e}), 32'd0);
    chk("rst_cnt", 32'({cnt_a, cnt_e}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    step();

    // Single pair: result two cycles after the words, one cycle wide.
    cyc_drive(1'b1, 32'd5, 1'b1, 32'd7);
    exp_q.push_back(32'd12);
    chk("pair_n1_valid", 32'(out_cValid), 32'd0);
    idle();
    chk("pair_n2_valid", 32'(out_cValid), 32'd1);
    chk("pair_n2_c", out_c, 32'd12);
    idle();
    chk("pair_n3_valid", 32'(out_cValid), 32'd0);
    idle();

    // Skewed arrival: a words wait for their e partners.
    cyc_drive(1'b1, 32'h10, 1'b0, 32'd0);
    cyc_drive(1'b1, 32'h20, 1'b0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("skew_cnt_a", 32'(cnt_a), 32'd2);
      idle();
    end
    chk("skew_cnt_a", 32'(cnt_a), 32'd2);
    cyc_drive(1'b0, 32'd0, 1'b1, 32'd1);
    exp_q.push_back(32'h11);
    cyc_drive(1'b0, 32'd0, 1'b1, 32'd2);
    exp_q.push_back(32'h22);
    chk("skew_c0", out_c, 32'h11);
    idle();
    chk("skew_c1", out_c, 32'h22);
    idle();
    idle();

    // Overflow: fifth a word hits a full FIFO and is lost.
    for (int i = 1; i <= 5; i++) cyc_drive(1'b1, 32'(i), 1'b0, 32'd0);
    chk("ovf_cnt_a", 32'(cnt_a), 32'd4);
    chk("ovf_a_set", 32'(ovf_a), 32'd1);
    chk("ovf_e_clear", 32'(ovf_e), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      cyc_drive(1'b0, 32'd0, 1'b1, 32'd0);
      exp_q.push_back(32'(i));
    end
    for (int i = 0; i < 4; i++) idle();
    chk("ovf_drained_cnt", 32'(cnt_a), 32'd0);
    chk("ovf_sticky", 32'(ovf_a), 32'd1);
    chk("ovf_sb_empty", 32'(exp_q.size()), 32'd0);
    clr_ovf = 1'b1;
    idle();
    clr_ovf = 1'b0;
    chk("ovf_cleared", 32'(ovf_a), 32'd0);

    // Backpressure: output holds while three pairs queue up.
    out_cReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc_drive(1'b1, 32'(2 * i + 1), 1'b1, 32'(2 * i + 2));
      exp_q.push_back(32'(4 * i + 3));
    end
    for (int i = 0; i < 3; i++) begin
      chk("bp_hold_valid", 32'(out_cValid), 32'd1);
      chk("bp_hold_c", out_c, 32'd3);
      idle();
    end
    chk("bp_cnt_a", 32'(cnt_a), 32'd2);
    chk("bp_cnt_e", 32'(cnt_e), 32'd2);
    snap = n_xfer;
    out_cReady = 1'b1;
    for (int i = 0; i < 3; i++) idle();
    chk("bp_burst", 32'(n_xfer - snap), 32'd3);
    chk("bp_after_valid", 32'(out_cValid), 32'd0);

    // Full with simultaneous pop: the write is accepted and the count stays at DEPTH.
    out_cReady = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc_drive(1'b1, 32'(10 + i), 1'b1, 32'd1);
      exp_q.push_back(32'(11 + i));
    end
    chk("fp_cnt_a_full", 32'(cnt_a), 32'd4);
    chk("fp_cnt_e_full", 32'(cnt_e), 32'd4);
    out_cReady = 1'b1;
    cyc_drive(1'b1, 32'd20, 1'b1, 32'd1);
    exp_q.push_back(32'd21);
    chk("fp_cnt_a_kept", 32'(cnt_a), 32'd4);
    chk("fp_no_drop", 32'({ovf_a, ovf_e}), 32'd0);
    for (int i = 0; i < 7; i++) idle();
    chk("fp_sb_empty", 32'(exp_q.size()), 32'd0);

    // Streaming with wrap: a=i, e=all-ones gives i-1, one result per cycle.
    snap = n_xfer;
    for (int i = 0; i < 20; i++) begin
      cyc_drive(1'b1, 32'(i), 1'b1, 32'hFFFF_FFFF);
      exp_q.push_back(32'(i) - 32'd1);
    end
    idle();
    idle();
    chk("wrap_throughput", 32'(n_xfer - snap), 32'd20);
    chk("wrap_no_ovf", 32'({ovf_a, ovf_e}), 32'd0);

    // Asynchronous reset while busy.
    out_cReady = 1'b0;
    cyc_drive(1'b1, 32'd1, 1'b1, 32'd1);
    exp_q.push_back(32'd2);
    for (int i = 0; i < 3; i++) cyc_drive(1'b1, 32'd7, 1'b0, 32'd0);
    chk("pre_rst_cnt_a", 32'(cnt_a), 32'd3);
    chk("pre_rst_valid", 32'(out_cValid), 32'd1);
    in_aValid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_cValid), 32'd0);
    chk("arst_c", out_c, 32'd0);
    chk("arst_cnt", 32'({cnt_a, cnt_e}), 32'd0);
    chk("arst_ovf", 32'({ovf_a, ovf_e}), 32'd0);
    exp_q.delete();
    out_cReady = 1'b1;
    #3 rst_n = 1'b1;
    step();
    step();
    cyc_drive(1'b1, 32'd2, 1'b1, 32'd3);
    exp_q.push_back(32'd5);
    chk("post_rst_n1", 32'(out_cValid), 32'd0);
    idle();
    chk("post_rst_valid", 32'(out_cValid), 32'd1);
    chk("post_rst_c", out_c, 32'd5);
    idle();
    idle();

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
